// File: rtl/wb_dma_pkg.sv
// Shared state encoding and bus constants for the Wishbone DMA copy engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0]  WB_SEL_ALL = 4'hF;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/wb_dma_timeout.sv
// Ack watchdog: flags a strobe left unacknowledged for TIMEOUT consecutive cycles.
// Latency: expired is combinational on the TIMEOUT-th waiting cycle.
// Backpressure: none; only exists when WB_DMA_TIMEOUT_EN is defined.
`ifdef WB_DMA_TIMEOUT_EN
module wb_dma_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of waiting cycles already elapsed, so the current one is cnt+1
  assign expired = stb & ~ack & (cnt == CNT_W'(TIMEOUT - 1));

  // Count waiting cycles; any ack, idle bus or abort restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!stb || ack || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/wb_dma_master.sv
// Wishbone memory-to-memory copy master: read word i from src, write it to dst, repeat len times.
// Latency: 4N+2 cycles start-to-done with a registered zero-wait slave; len==0 finishes in 2.
// Backpressure: each strobe is held until ack; optional watchdog (WB_DMA_TIMEOUT_EN) aborts a stalled copy.
module wb_dma_master
  import wb_dma_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_adr_i,
  input  logic [ADDR_W-1:0] dst_adr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i
);

  state_t            state, state_n;
  logic [LEN_W-1:0]  idx, idx_n, len, len_n, idx_inc;
  logic [ADDR_W-1:0] src, src_n, dst, dst_n, adr_n;
  logic              cyc_n, stb_n, we_n, busy_n, done_n, err_n;
  logic [3:0]        sel_n;
  logic [31:0]       dat_n;
  logic              ack, tmo_hit;

  // A stray ack with no strobe outstanding must not advance anything
  assign ack     = wbm_ack_i & wbm_stb_o;
  assign idx_inc = idx + LEN_W'(1);

`ifdef WB_DMA_TIMEOUT_EN
  wb_dma_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .stb     (wbm_stb_o),
    .ack     (wbm_ack_i),
    .expired (tmo_hit)
  );
`else
  assign tmo_hit = 1'b0;
`endif

  // Byte address of word i; wraps naturally at the top of the address space
  function automatic logic [ADDR_W-1:0] word_adr(input logic [ADDR_W-1:0] base,
                                                 input logic [LEN_W-1:0]  i);
    return base + ADDR_W'(i) * ADDR_W'(WORD_BYTES);
  endfunction

  // Next-state and next-output decode; every output is the registered copy of these
  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len;
    src_n   = src;
    dst_n   = dst;
    cyc_n   = wbm_cyc_o;
    stb_n   = wbm_stb_o;
    we_n    = wbm_we_o;
    sel_n   = wbm_sel_o;
    adr_n   = wbm_adr_o;
    dat_n   = wbm_dat_o;
    busy_n  = busy_o;
    done_n  = 1'b0;
    err_n   = err_o;
    case (state)
      IDLE: begin
        if (start_i) begin
          src_n  = src_adr_i;
          dst_n  = dst_adr_i;
          len_n  = len_i;
          idx_n  = '0;
          err_n  = 1'b0;
          busy_n = 1'b1;
          if (len_i == '0) begin
            state_n = DONE;
          end else begin
            state_n = READ;
            cyc_n   = 1'b1;
            stb_n   = 1'b1;
            we_n    = 1'b0;
            sel_n   = WB_SEL_ALL;
            adr_n   = src_adr_i;
          end
        end
      end
      READ, WRITE: begin
        if (tmo_hit) begin
          state_n = DONE;
          cyc_n   = 1'b0;
          stb_n   = 1'b0;
          we_n    = 1'b0;
          sel_n   = '0;
          err_n   = 1'b1;
        end else if (ack && state == READ) begin
          // Keep the cycle open and turn straight around into the write
          state_n = WRITE;
          dat_n   = wbm_dat_i;
          we_n    = 1'b1;
          adr_n   = word_adr(dst, idx);
        end else if (ack) begin
          if (idx == len - LEN_W'(1)) begin
            state_n = DONE;
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            we_n    = 1'b0;
            sel_n   = '0;
          end else begin
            state_n = READ;
            idx_n   = idx_inc;
            we_n    = 1'b0;
            adr_n   = word_adr(src, idx_inc);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, operands and registered bus outputs; reset clears everything immediately
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      idx       <= '0;
      len       <= '0;
      src       <= '0;
      dst       <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      len       <= len_n;
      src       <= src_n;
      dst       <= dst_n;
      wbm_cyc_o <= cyc_n;
      wbm_stb_o <= stb_n;
      wbm_we_o  <= we_n;
      wbm_sel_o <= sel_n;
      wbm_adr_o <= adr_n;
      wbm_dat_o <= dat_n;
      busy_o    <= busy_n;
      done_o    <= done_n;
      err_o     <= err_n;
    end
  end

endmodule
